esfa_op_sequencer: RTL

//  Sequences high-level ESFA requests (lookup, alloc/insert, rank query, remove) onto a broadcast bus shared by N_CELLS memory cells.

---
 rtl/esfa_op_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/esfa_op_sequencer.sv
// ESFA operation sequencer: expands host requests into one or two broadcast
// cell steps and returns a single priority-encoded response per request.
module esfa_op_sequencer #(
    parameter int         N_CELLS  = 8,
    parameter logic [7:0] IDLE_SEL = 8'd8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [7:0]           req_arr,
    input  logic [7:0]           req_idx,
    input  logic [7:0]           req_val,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_hit,
    output logic [7:0]           resp_value,
    output logic [7:0]           resp_cell,
    output logic [7:0]           cell_selector,
    output logic [7:0]           cell_metadata,
    output logic                 cell_is_meta,
    output logic [7:0]           cell_index,
    output logic [7:0]           cell_value,
    input  logic [N_CELLS-1:0]   cell_bool,
    input  logic [8*N_CELLS-1:0] cell_result
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SAMPLE, S_RESP} state_t;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_ALLOC  = 2'd1,
        OP_RANK   = 2'd2,
        OP_REMOVE = 2'd3
    } op_t;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] meta;
        logic       is_meta;
        logic [7:0] index;
        logic [7:0] value;
    } cmd_t;

    localparam cmd_t IDLE_CMD = cmd_t'{IDLE_SEL, 8'd0, 1'b0, 8'd0, 8'd0};

    state_t     state;
    op_t        op_q;
    logic       step_q;
    logic [7:0] arr_q;
    logic [7:0] idx_q;
    logic [7:0] val_q;
    logic [7:0] link_q;
    cmd_t       cmd_q;

    logic       win_any;
    logic [7:0] win_idx;
    logic [7:0] win_res;
    logic [7:0] next_link;

    // Bus command for a given step; step 1 carries the code or free handle found by step 0.
    function automatic cmd_t step_cmd(input op_t op, input logic step,
                                      input logic [7:0] arr, input logic [7:0] idx,
                                      input logic [7:0] val, input logic [7:0] link);
        cmd_t c;
        c = IDLE_CMD;
        case (op)
            OP_LOOKUP: c = step ? cmd_t'{8'd1, link, 1'b1, idx, 8'd0}
                                : cmd_t'{8'd2, arr, 1'b1, 8'd0, 8'd0};
            OP_ALLOC:  c = step ? cmd_t'{8'd0, link, 1'b1, idx, val}
                                : cmd_t'{8'd5, 8'd0, 1'b0, 8'd0, 8'd0};
            OP_RANK:   c = cmd_t'{8'd6, arr, 1'b1, 8'd0, 8'd0};
            OP_REMOVE: c = cmd_t'{8'd4, idx, 1'b1, arr, 8'd0};
            default:   c = IDLE_CMD;
        endcase
        return c;
    endfunction

    // Lowest-handle priority encoder; a miss yields handle 8'hFF and result 0.
    always_comb begin
        win_any = 1'b0;
        win_idx = 8'hFF;
        win_res = 8'h00;
        for (int k = N_CELLS - 1; k >= 0; k--) begin
            if (cell_bool[k]) begin
                win_any = 1'b1;
                win_idx = 8'(k);
                win_res = cell_result[8*k +: 8];
            end
        end
    end

    assign next_link = (op_q == OP_ALLOC) ? win_idx : win_res;

    assign cell_selector = cmd_q.sel;
    assign cell_metadata = cmd_q.meta;
    assign cell_is_meta  = cmd_q.is_meta;
    assign cell_index    = cmd_q.index;
    assign cell_value    = cmd_q.value;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_LOOKUP;
            step_q     <= 1'b0;
            arr_q      <= 8'd0;
            idx_q      <= 8'd0;
            val_q      <= 8'd0;
            link_q     <= 8'd0;
            cmd_q      <= IDLE_CMD;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_value <= 8'd0;
            resp_cell  <= 8'hFF;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_t'(req_op);
                        arr_q     <= req_arr;
                        idx_q     <= req_idx;
                        val_q     <= req_val;
                        step_q    <= 1'b0;
                        cmd_q     <= step_cmd(op_t'(req_op), 1'b0, req_arr, req_idx, req_val, 8'd0);
                        req_ready <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd_q <= IDLE_CMD;
                    state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (!step_q && win_any && (op_q == OP_LOOKUP || op_q == OP_ALLOC)) begin
                        link_q <= next_link;
                        step_q <= 1'b1;
                        cmd_q  <= step_cmd(op_q, 1'b1, arr_q, idx_q, val_q, next_link);
                        state  <= S_ISSUE;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                        if (op_q == OP_REMOVE) begin
                            resp_hit   <= 1'b1;
                            resp_value <= 8'd0;
                            resp_cell  <= arr_q;
                        end else if (op_q == OP_ALLOC && step_q) begin
                            resp_hit   <= 1'b1;
                            resp_value <= link_q;
                            resp_cell  <= link_q;
                        end else begin
                            resp_hit   <= win_any;
                            resp_value <= win_res;
                            resp_cell  <= win_idx;
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
